// File: rtl/denise_clut_if.sv
// Bundle between the CLUT arbiter, the CPU colour-register port, the pixel pipeline and the CLUT RAM.
interface denise_clut_if #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned RGB_W = 12
);
  logic             cpu_wr;
  logic [IDX_W-1:0] cpu_idx;
  logic [RGB_W-1:0] cpu_rgb;
  logic             pix_rd;
  logic [IDX_W-1:0] pix_idx;
  logic [RGB_W-1:0] pix_rgb;
  logic             pix_valid;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [RGB_W-1:0] ram_wdata;
  logic [RGB_W-1:0] ram_rdata;
  logic             ovf;
  logic             ovf_clr;
  logic             pending;

  modport master (
    output cpu_wr, cpu_idx, cpu_rgb, pix_rd, pix_idx, ram_rdata, ovf_clr,
    input  pix_rgb, pix_valid, ram_we, ram_addr, ram_wdata, ovf, pending
  );

  modport slave (
    input  cpu_wr, cpu_idx, cpu_rgb, pix_rd, pix_idx, ram_rdata, ovf_clr,
    output pix_rgb, pix_valid, ram_we, ram_addr, ram_wdata, ovf, pending
  );
endinterface

// File: rtl/denise_clut_arbiter.sv
// Shares the single-port CLUT RAM between pixel lookups (priority) and queued CPU colour writes,
// with write coalescing and read forwarding from the pending-write queue.
module denise_clut_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned RGB_W = 12
) (
  input logic          clk,
  input logic          rst_n,
  denise_clut_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR
  } slot_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [RGB_W-1:0] rgb;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d, count;
  logic [AW-1:0]    head_ptr, age, slot;
  logic [DEPTH-1:0] ent_valid;
  logic             full, pending_q, pending_d, ovf_q;
  logic             push, pop, drop;
  logic             co_hit;
  logic [AW-1:0]    co_slot;
  logic             fwd_hit, fwd_hit_q;
  logic [RGB_W-1:0] fwd_data, fwd_data_q;
  logic [RGB_W-1:0] pix_rgb_q;
  logic             pix_valid_q;
  slot_e            slot_q, slot_d;
  logic             we_c;
  logic [IDX_W-1:0] addr_c, addr_q;
  logic [RGB_W-1:0] wdata_c, wdata_q;
  entry_t           head;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_ptr = rd_ptr_q[AW-1:0];
  assign head     = fifo_q[head_ptr];

  // Slot selection: pixel reads always win, writes drain only in idle slots
  always_comb begin
    slot_d  = SLOT_IDLE;
    we_c    = 1'b0;
    pop     = 1'b0;
    addr_c  = addr_q;
    wdata_c = wdata_q;
    if (bus.pix_rd) begin
      slot_d = SLOT_RD;
      addr_c = bus.pix_idx;
    end else if (pending_q) begin
      slot_d  = SLOT_WR;
      we_c    = 1'b1;
      pop     = 1'b1;
      addr_c  = head.idx;
      wdata_c = head.rgb;
    end
  end

  // Queue searches: occupancy by age, newest-match forwarding, coalesce target
  always_comb begin
    ent_valid = '0;
    age       = '0;
    slot      = '0;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    co_hit    = 1'b0;
    co_slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = AW'(i) - head_ptr;
      ent_valid[i] = ({1'b0, age} < count);
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_ptr + AW'(k);
      if ((PW'(k) < count) && (fifo_q[slot].idx == bus.pix_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[slot].rgb;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.cpu_wr && ent_valid[i] && !(pop && (AW'(i) == head_ptr)) &&
          (fifo_q[i].idx == bus.cpu_idx)) begin
        co_hit  = 1'b1;
        co_slot = AW'(i);
      end
    end
  end

  assign push      = bus.cpu_wr && !co_hit && (!full || pop);
  assign drop      = bus.cpu_wr && !co_hit && full && !pop;
  assign wr_ptr_d  = wr_ptr_q + PW'(push);
  assign rd_ptr_d  = rd_ptr_q + PW'(pop);
  assign pending_d = (wr_ptr_d != rd_ptr_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_IDLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pending_q <= pending_d;
      addr_q    <= addr_c;
      wdata_q   <= wdata_c;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Queue storage carries no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= '{idx: bus.cpu_idx, rgb: bus.cpu_rgb};
    end else if (co_hit) begin
      fifo_q[co_slot].rgb <= bus.cpu_rgb;
    end
  end

  // Read pipeline: forward snapshot taken at issue, merged with RAM data one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      fwd_hit_q   <= bus.pix_rd && fwd_hit;
      if (bus.pix_rd) begin
        fwd_data_q <= fwd_data;
      end
      pix_valid_q <= (slot_q == SLOT_RD);
      if (slot_q == SLOT_RD) begin
        pix_rgb_q <= fwd_hit_q ? fwd_data_q : bus.ram_rdata;
      end
    end
  end

  assign bus.ram_we    = we_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_wdata = wdata_c;
  assign bus.pix_rgb   = pix_rgb_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_denise_clut_arbiter.sv
// Scoreboard bench for denise_clut_arbiter: directed pixel reads and CPU writes against a RAM model.
module tb_denise_clut_arbiter;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    int               due;
    logic [RGB_W-1:0] rgb;
  } rd_exp_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [RGB_W-1:0] rgb;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic seeded = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [RGB_W-1:0] ram [32];
  rd_exp_t exp_rd [$];
  wr_exp_t exp_wr [$];

  always #5 clk = ~clk;

  denise_clut_if #(.IDX_W(IDX_W), .RGB_W(RGB_W)) bus ();

  denise_clut_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RGB_W(RGB_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port CLUT RAM; seeded with 0x100|idx, RAM[3]=0x0F0, RAM[5]=0x555
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) ram[i] <= 12'h100 | 12'(i);
      ram[3]   <= 12'h0F0;
      ram[5]   <= 12'h555;
      seeded   <= 1'b1;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a pixel or a RAM write
  initial begin
    rd_exp_t er;
    wr_exp_t ew;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.pix_valid) begin
          if (exp_rd.size() == 0) begin
            check("rd_unexpected", 32'(bus.pix_valid), 0);
          end else begin
            er = exp_rd.pop_front();
            check("rd_latency", cyc, er.due);
            check("rd_rgb", 32'(bus.pix_rgb), 32'(er.rgb));
          end
        end else if (exp_rd.size() != 0 && exp_rd[0].due < cyc) begin
          er = exp_rd.pop_front();
          check("rd_missing", 32'(bus.pix_valid), 1);
        end
        if (bus.ram_we) begin
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", 32'(bus.ram_we), 0);
          end else begin
            ew = exp_wr.pop_front();
            check("wr_idx", 32'(bus.ram_addr), 32'(ew.idx));
            check("wr_data", 32'(bus.ram_wdata), 32'(ew.rgb));
          end
        end
      end
    end
  end

  task automatic expect_wr(input int idx, input int rgb);
    exp_wr.push_back('{idx: 5'(idx), rgb: 12'(rgb)});
  endtask

  // One cycle of stimulus, entered and left at posedge+1
  task automatic drive(input logic rd, input int ridx, input int rexp,
                       input logic wr, input int widx, input int wrgb, input logic clr);
    bus.pix_rd  = rd;
    bus.pix_idx = 5'(ridx);
    bus.cpu_wr  = wr;
    bus.cpu_idx = 5'(widx);
    bus.cpu_rgb = 12'(wrgb);
    bus.ovf_clr = clr;
    if (rd) exp_rd.push_back('{due: cyc + 2, rgb: 12'(rexp)});
    @(negedge clk);
    if (rd) check("we_during_rd", 32'(bus.ram_we), 0);
    @(posedge clk);
    #1;
    bus.pix_rd  = 1'b0;
    bus.cpu_wr  = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic rd(input int idx, input int exp);
    drive(1'b1, idx, exp, 1'b0, 0, 0, 1'b0);
  endtask

  // CPU write hidden under a pixel read of index 0 (RAM[0]=0x100)
  task automatic rw(input int idx, input int rgb);
    drive(1'b1, 0, 12'h100, 1'b1, idx, rgb, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_wr  = 1'b0;
    bus.cpu_idx = '0;
    bus.cpu_rgb = '0;
    bus.pix_rd  = 1'b0;
    bus.pix_idx = '0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_valid", 32'(bus.pix_valid), 0);
    check("rst_pix_rgb", 32'(bus.pix_rgb), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain lookup
    rd(3, 12'h0F0);
    idle(3);

    // Forward a write queued during a read burst, then drain it
    rw(5, 12'hABC);
    expect_wr(5, 12'hABC);
    rd(5, 12'hABC);
    rd(0, 12'h100);
    idle(3);
    check("t2_pending", 32'(bus.pending), 0);
    rd(5, 12'hABC);

    // Coalesce two writes to the same index
    rw(7, 12'h111);
    rw(7, 12'h222);
    expect_wr(7, 12'h222);
    rd(7, 12'h222);
    idle(3);

    // Overflow: fifth distinct write under reads is dropped
    for (int i = 0; i < 5; i++) begin
      rw(10 + i, 12'hA01 + i);
      if (i < 4) expect_wr(10 + i, 12'hA01 + i);
      if (i == 3) check("t4_ovf_before", 32'(bus.ovf), 0);
    end
    check("t4_ovf_set", 32'(bus.ovf), 1);
    check("t4_pending", 32'(bus.pending), 1);
    drive(1'b1, 0, 12'h100, 1'b0, 0, 0, 1'b1);
    check("t4_ovf_clr", 32'(bus.ovf), 0);
    idle(6);
    check("t4_drained", 32'(bus.pending), 0);
    rd(14, 12'h10E);
    rd(13, 12'hA04);
    idle(3);

    // Full queue: pop and push in the same idle slot
    for (int i = 0; i < 4; i++) begin
      rw(16 + i, 12'hB01 + i);
      expect_wr(16 + i, 12'hB01 + i);
    end
    check("t5_pending", 32'(bus.pending), 1);
    drive(1'b0, 0, 0, 1'b1, 20, 12'hB05, 1'b0);
    expect_wr(20, 12'hB05);
    check("t5_ovf_push_pop", 32'(bus.ovf), 0);
    drive(1'b1, 0, 12'h100, 1'b1, 21, 12'hB06, 1'b0);
    check("t5_ovf_still_full", 32'(bus.ovf), 1);
    drive(1'b1, 0, 12'h100, 1'b0, 0, 0, 1'b1);
    check("t5_ovf_clr", 32'(bus.ovf), 0);
    idle(7);
    check("t5_drained", 32'(bus.pending), 0);
    rd(21, 12'h115);
    rd(20, 12'hB05);
    idle(3);

    // Reset mid-drain with three queued writes
    rw(24, 12'hC01);
    rw(25, 12'hC02);
    rw(26, 12'hC03);
    expect_wr(24, 12'hC01);
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 0, 12'h100, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    exp_rd.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_ram_we", 32'(bus.ram_we), 0);
      check("t6_pending", 32'(bus.pending), 0);
      check("t6_pix_valid", 32'(bus.pix_valid), 0);
    end
    check("t6_pix_rgb", 32'(bus.pix_rgb), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check("t6_pending_after", 32'(bus.pending), 0);
    rd(25, 12'h119);
    rd(24, 12'hC01);
    rd(26, 12'h11A);
    idle(3);

    for (int i = 0; i < 20 && (exp_rd.size() != 0 || exp_wr.size() != 0); i++) @(posedge clk);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
